// File: rtl/uart_command_loader_pkg.sv
// Shared bus defaults, parser/receiver state encodings and the header layout
// for the UART command loader.
package uart_command_loader_pkg;

    localparam int SLAVE_LEN_DEF = 2;
    localparam int ADDR_LEN_DEF  = 12;
    localparam int DATA_LEN_DEF  = 8;
    localparam int BURST_LEN_DEF = 12;

    localparam logic [3:0] SYNC_NIBBLE = 4'hA;

    typedef enum logic [2:0] {
        P_HDR,
        P_AH,
        P_AL,
        P_BH,
        P_BL,
        P_DAT,
        P_ISSUE
    } parse_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Upper nibble of the HDR byte.
    typedef struct packed {
        logic       master;
        logic       write;
        logic [1:0] slave;
    } hdr_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver working on an already-synchronized serial line; all
// samples are taken mid-bit relative to the detected start edge.
module uart_rx_byte
    import uart_command_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       stop_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shift, shift_n;
    logic             rx_prev;
    logic             valid_n, err_n;

    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        valid_n   = 1'b0;
        err_n     = 1'b0;
        unique case (state)
            RX_IDLE: begin
                cnt_n = '0;
                if (rx_prev && !rx) state_n = RX_START;
            end
            RX_START: begin
                // A start bit that is high again at mid-bit was a glitch.
                if (cnt == HALF_LAST) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = rx ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == FULL_LAST) begin
                    cnt_n     = '0;
                    shift_n   = {rx, shift[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == FULL_LAST) begin
                    state_n = RX_IDLE;
                    valid_n = rx;
                    err_n   = !rx;
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            rx_prev    <= 1'b1;
            byte_valid <= 1'b0;
            stop_err   <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_idx_n;
            shift      <= shift_n;
            rx_prev    <= rx;
            byte_valid <= valid_n;
            stop_err   <= err_n;
        end
    end

    assign byte_data = shift;

endmodule

// File: rtl/uart_command_loader.sv
// Parses 6-byte UART frames into read/write commands for two bus masters,
// holding a decoded command while its master is busy.
module uart_command_loader
    import uart_command_loader_pkg::*;
#(
    parameter int SLAVE_LEN    = SLAVE_LEN_DEF,
    parameter int ADDR_LEN     = ADDR_LEN_DEF,
    parameter int DATA_LEN     = DATA_LEN_DEF,
    parameter int BURST_LEN    = BURST_LEN_DEF,
    parameter int CLKS_PER_BIT = 16,
    parameter int GAP_LIMIT    = 320
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rx,
    input  logic                 m1_busy,
    input  logic                 m2_busy,
    output logic                 read1,
    output logic                 write1,
    output logic [DATA_LEN-1:0]  data1,
    output logic [ADDR_LEN:0]    address1,
    output logic [SLAVE_LEN-1:0] slave1,
    output logic [BURST_LEN:0]   burst_num1,
    output logic                 read2,
    output logic                 write2,
    output logic [DATA_LEN-1:0]  data2,
    output logic [ADDR_LEN:0]    address2,
    output logic [SLAVE_LEN-1:0] slave2,
    output logic [BURST_LEN:0]   burst_num2,
    output logic                 cmd_pending,
    output logic                 frame_err
);

    localparam int ADDR_W  = ADDR_LEN + 1;
    localparam int BURST_W = BURST_LEN + 1;
    localparam int GAP_W   = $clog2(GAP_LIMIT + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LIMIT - 1);

    logic [1:0]       sync_q;
    logic             rx_s;
    logic             byte_valid, stop_err;
    logic [7:0]       byte_data;

    parse_state_t     state, state_n;
    hdr_t             hdr_q;
    logic [12:0]      addr_q, burst_q;
    logic [7:0]       data_q;
    logic             held_valid;
    logic [7:0]       held_data;
    logic [GAP_W-1:0] gap_cnt;

    logic             tgt_busy, issue;
    logic             in_valid, in_frame, bad_sync, gap_hit, abort;
    logic [7:0]       in_byte;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= 2'b11;
        else      sync_q <= {sync_q[0], uart_rx};
    end
    assign rx_s = sync_q[1];

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx_s),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .stop_err   (stop_err)
    );

    // A byte landing during ISSUE is parked and replayed once the command is out.
    assign in_valid = (state != P_ISSUE) && (held_valid || byte_valid);
    assign in_byte  = held_valid ? held_data : byte_data;
    assign in_frame = state inside {P_AH, P_AL, P_BH, P_BL, P_DAT};
    assign bad_sync = (state == P_HDR) && in_valid && (in_byte[3:0] != SYNC_NIBBLE);
    assign gap_hit  = in_frame && rx_s && !in_valid && (gap_cnt == GAP_LAST);
    assign abort    = (stop_err && state != P_ISSUE) || gap_hit;

    always_comb begin
        state_n     = state;
        tgt_busy    = hdr_q.master ? m2_busy : m1_busy;
        issue       = 1'b0;
        cmd_pending = 1'b0;
        unique case (state)
            P_HDR:   if (in_valid && !bad_sync) state_n = P_AH;
            P_AH:    if (in_valid) state_n = P_AL;
            P_AL:    if (in_valid) state_n = P_BH;
            P_BH:    if (in_valid) state_n = P_BL;
            P_BL:    if (in_valid) state_n = P_DAT;
            P_DAT:   if (in_valid) state_n = P_ISSUE;
            P_ISSUE: begin
                if (tgt_busy) begin
                    cmd_pending = 1'b1;
                end else begin
                    issue   = 1'b1;
                    state_n = P_HDR;
                end
            end
            default: state_n = P_HDR;
        endcase
        if (abort) state_n = P_HDR;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= P_HDR;
        else      state <= state_n;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hdr_q      <= '0;
            addr_q     <= '0;
            burst_q    <= '0;
            data_q     <= '0;
            held_valid <= 1'b0;
            held_data  <= '0;
            gap_cnt    <= '0;
            frame_err  <= 1'b0;
            read1      <= 1'b0;
            write1     <= 1'b0;
            data1      <= '0;
            address1   <= '0;
            slave1     <= '0;
            burst_num1 <= '0;
            read2      <= 1'b0;
            write2     <= 1'b0;
            data2      <= '0;
            address2   <= '0;
            slave2     <= '0;
            burst_num2 <= '0;
        end else begin
            if (byte_valid && (state == P_ISSUE || held_valid)) begin
                held_data  <= byte_data;
                held_valid <= 1'b1;
            end else if (in_valid && held_valid) begin
                held_valid <= 1'b0;
            end

            if (in_valid && !abort) begin
                unique case (state)
                    P_HDR:   if (!bad_sync) hdr_q <= in_byte[7:4];
                    P_AH:    addr_q[12:8]  <= in_byte[4:0];
                    P_AL:    addr_q[7:0]   <= in_byte;
                    P_BH:    burst_q[12:8] <= in_byte[4:0];
                    P_BL:    burst_q[7:0]  <= in_byte;
                    P_DAT:   data_q        <= in_byte;
                    default: ;
                endcase
            end

            if (!in_frame || !rx_s || in_valid) gap_cnt <= '0;
            else if (!gap_hit)                  gap_cnt <= gap_cnt + 1'b1;

            if (stop_err || bad_sync || gap_hit) frame_err <= 1'b1;
            else if (issue)                      frame_err <= 1'b0;

            read1  <= issue && !hdr_q.master && !hdr_q.write;
            write1 <= issue && !hdr_q.master &&  hdr_q.write;
            read2  <= issue &&  hdr_q.master && !hdr_q.write;
            write2 <= issue &&  hdr_q.master &&  hdr_q.write;

            if (issue && !hdr_q.master) begin
                data1      <= DATA_LEN'(data_q);
                address1   <= ADDR_W'(addr_q);
                slave1     <= SLAVE_LEN'(hdr_q.slave);
                burst_num1 <= BURST_W'(burst_q);
            end
            if (issue && hdr_q.master) begin
                data2      <= DATA_LEN'(data_q);
                address2   <= ADDR_W'(addr_q);
                slave2     <= SLAVE_LEN'(hdr_q.slave);
                burst_num2 <= BURST_W'(burst_q);
            end
        end
    end

endmodule
